// File: rtl/rom_fifo_loader_if.sv
// rom_fifo_loader_if: run control, ROM read port and FIFO write port of the ROM-to-FIFO loader.
//   start        - level run request (into loader)
//   done, busy   - run status (from loader)
//   rom_en       - ROM read enable, data returns one cycle later (from loader)
//   rom_addr     - ROM read address (from loader)
//   rom_data     - ROM read data (into loader)
//   fifo_full    - FIFO cannot accept a write (into loader)
//   fifo_wr_en   - FIFO write strobe (from loader)
//   fifo_wr_data - word written to the FIFO (from loader)
interface rom_fifo_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  start, done, busy;
    logic                  rom_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  fifo_full, fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_wr_data;
    modport master (
        input  start, rom_data, fifo_full,
        output done, busy, rom_en, rom_addr, fifo_wr_en, fifo_wr_data
    );
    modport slave (
        output start, rom_data, fifo_full,
        input  done, busy, rom_en, rom_addr, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/rom_fifo_loader.sv
// rom_fifo_loader: streams DATA_AMOUNT ROM words into a FIFO write port through a 2-entry skid buffer.
//   clk   - single clock, rising edge
//   reset - synchronous active-high reset
//   bus   - master side of rom_fifo_loader_if (run control, ROM read, FIFO write)
module rom_fifo_loader #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int DATA_AMOUNT  = 16,
    localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               reset,
    rom_fifo_loader_if.master bus
);
    localparam int CW = $clog2(DATA_AMOUNT + 1);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t                state_q, state_d;
    logic [CW-1:0]         issue_q, issue_d, wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, head_q, last_wr;
    logic [DATA_WIDTH-1:0] buf_q [2];

    assign last_wr = bus.fifo_wr_en && wr_q == CW'(DATA_AMOUNT - 1);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    if (last_wr) state_d = DONE;
            DONE:    if (!bus.start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A read is only issued if its word is guaranteed a buffer slot when it returns,
    // counting words already buffered, the read in flight and the word leaving this cycle.
    always_comb begin
        bus.busy         = state_q == LOAD;
        bus.done         = state_q == DONE;
        bus.fifo_wr_en   = occ_q != 2'd0 && !bus.fifo_full;
        bus.rom_en       = state_q == LOAD && issue_q < CW'(DATA_AMOUNT) &&
                           ({1'b0, occ_q} + {2'b0, inflight_q} < 3'd2 + {2'b0, bus.fifo_wr_en});
        bus.rom_addr     = addr_q;
        bus.fifo_wr_data = buf_q[head_q];
    end

    always_comb begin
        issue_d = state_q == IDLE ? '0 : issue_q + CW'(bus.rom_en);
        wr_d    = state_q == IDLE ? '0 : wr_q + CW'(bus.fifo_wr_en);
        addr_d  = state_q == IDLE ? '0 : !bus.rom_en ? addr_q :
                  addr_q == ADDR_WIDTH'(DEPTH - 1) ? '0 : addr_q + ADDR_WIDTH'(1);
        occ_d   = occ_q + {1'b0, inflight_q} - {1'b0, bus.fifo_wr_en};
    end

    // Returning words go to the tail slot (head + occupancy); when full, the head is popped this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_q    <= '0;
            wr_q       <= '0;
            addr_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            issue_q    <= issue_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            occ_q      <= occ_d;
            inflight_q <= bus.rom_en;
            head_q     <= head_q ^ bus.fifo_wr_en;
            if (inflight_q) buf_q[head_q ^ occ_q[0]] <= bus.rom_data;
        end
    end
endmodule

// File: tb/tb_rom_fifo_loader.sv
// tb_rom_fifo_loader: directed and random checks of rom_fifo_loader with a ROM model and scoreboards.
module tb_rom_fifo_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rom_fifo_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ia (), ib ();
    rom_fifo_loader #(.DATA_WIDTH(8), .DEPTH(16), .DATA_AMOUNT(16)) ua (.clk(clk), .reset(reset), .bus(ia));
    rom_fifo_loader #(.DATA_WIDTH(8), .DEPTH(16), .DATA_AMOUNT(20)) ub (.clk(clk), .reset(reset), .bus(ib));

    logic [7:0] rom [16];
    int n_checks = 0, n_fail = 0, en_a = 0, en_b = 0;
    logic [7:0] qd_a[$], qd_b[$];
    logic [3:0] qa_a[$], qa_b[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (ia.rom_en) ia.rom_data <= rom[ia.rom_addr];
        if (ib.rom_en) ib.rom_data <= rom[ib.rom_addr];
    end

    always @(negedge clk) begin
        chk("a_wr_while_full", 32'(ia.fifo_wr_en && ia.fifo_full), 0);
        if (ia.fifo_wr_en) begin
            chk("a_wr_expected", 32'(qd_a.size() != 0), 1);
            if (qd_a.size() != 0) chk("a_wr_data", 32'(ia.fifo_wr_data), 32'(qd_a.pop_front()));
        end
        if (ia.rom_en) begin
            en_a++;
            chk("a_rd_expected", 32'(qa_a.size() != 0), 1);
            if (qa_a.size() != 0) chk("a_rom_addr", 32'(ia.rom_addr), 32'(qa_a.pop_front()));
        end
        if (ib.fifo_wr_en) begin
            chk("b_wr_expected", 32'(qd_b.size() != 0), 1);
            if (qd_b.size() != 0) chk("b_wr_data", 32'(ib.fifo_wr_data), 32'(qd_b.pop_front()));
        end
        if (ib.rom_en) begin
            en_b++;
            chk("b_rd_expected", 32'(qa_b.size() != 0), 1);
            if (qa_b.size() != 0) chk("b_rom_addr", 32'(ib.rom_addr), 32'(qa_b.pop_front()));
        end
    end

    task automatic push_a();
        en_a = 0;
        for (int i = 0; i < 16; i++) begin
            qd_a.push_back(8'(i + 16));
            qa_a.push_back(4'(i));
        end
    endtask

    // Cycle c is the c-th cycle after the edge that samples start.
    task automatic run_a(input int lo, input int hi, input int ncyc, input int last, input int done_c, input bit hold);
        push_a();
        ia.start = 1'b1;
        @(posedge clk); #1;
        ia.start = hold;
        for (int c = 1; c <= ncyc; c++) begin
            ia.fifo_full = c >= lo && c <= hi;
            @(negedge clk);
            chk($sformatf("a_wr_en_c%0d", c), 32'(ia.fifo_wr_en), 32'(c >= 3 && c <= last && !(c >= lo && c <= hi)));
            chk($sformatf("a_done_c%0d", c), 32'(ia.done), 32'(hold ? c >= done_c : c == done_c));
            chk($sformatf("a_busy_c%0d", c), 32'(ia.busy), 32'(c < done_c));
            chk("a_occ_le2", 32'(ua.occ_q <= 2'd2), 1);
            @(posedge clk); #1;
        end
        ia.fifo_full = 1'b0;
        chk("a_rom_en_count", en_a, 16);
        chk("a_words_left", qd_a.size(), 0);
    endtask

    initial begin
        int c;
        for (int i = 0; i < 16; i++) rom[i] = 8'(i + 16);
        ia.start = 1'b0; ia.fifo_full = 1'b0;
        ib.start = 1'b0; ib.fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 32'(ia.done), 0);
        chk("rst_busy", 32'(ia.busy), 0);
        chk("rst_rom_en", 32'(ia.rom_en), 0);
        chk("rst_rom_addr", 32'(ia.rom_addr), 0);
        chk("rst_wr_en", 32'(ia.fifo_wr_en), 0);
        chk("rst_wr_data", 32'(ia.fifo_wr_data), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_a(0, 0, 20, 18, 19, 1'b0);
        run_a(4, 9, 26, 24, 25, 1'b0);

        for (int i = 0; i < 20; i++) begin
            qd_b.push_back(8'((i % 16) + 16));
            qa_b.push_back(4'(i % 16));
        end
        ib.start = 1'b1;
        @(posedge clk); #1;
        ib.start = 1'b0;
        c = 1;
        while (!ib.done && c < 60) begin
            @(posedge clk); #1;
            c++;
        end
        chk("b_done_cycle", c, 23);
        chk("b_rom_en_count", en_b, 20);
        chk("b_words_left", qd_b.size(), 0);
        chk("b_addrs_left", qa_b.size(), 0);
        @(posedge clk); #1;

        push_a();
        ia.start = 1'b1;
        @(posedge clk); #1;
        ia.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_words_written", 16 - qd_a.size(), 6);
        chk("mid_rst_reads_issued", 16 - qa_a.size(), 8);
        qd_a.delete();
        qa_a.delete();
        chk("mid_rst_done", 32'(ia.done), 0);
        chk("mid_rst_busy", 32'(ia.busy), 0);
        chk("mid_rst_rom_en", 32'(ia.rom_en), 0);
        chk("mid_rst_rom_addr", 32'(ia.rom_addr), 0);
        chk("mid_rst_wr_en", 32'(ia.fifo_wr_en), 0);
        chk("mid_rst_wr_data", 32'(ia.fifo_wr_data), 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_no_wr", 32'(ia.fifo_wr_en), 0);
        end
        run_a(0, 0, 20, 18, 19, 1'b0);

        run_a(0, 0, 26, 18, 19, 1'b1);
        ia.start = 1'b0;
        @(posedge clk); #1;
        chk("hold_release_done", 32'(ia.done), 0);
        run_a(0, 0, 20, 18, 19, 1'b0);

        for (int r = 0; r < 100; r++) begin
            push_a();
            ia.start = 1'b1;
            @(posedge clk); #1;
            ia.start = 1'b0;
            c = 0;
            while (!ia.done && c < 300) begin
                ia.fifo_full = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                c++;
            end
            ia.fifo_full = 1'b0;
            chk("rnd_done", 32'(ia.done), 1);
            chk("rnd_rom_en_count", en_a, 16);
            chk("rnd_words_left", qd_a.size(), 0);
            qd_a.delete();
            qa_a.delete();
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rom_fifo_loader.md
# rom_fifo_loader

Write-side source stage of the top-level transfer path: on a start request it streams DATA_AMOUNT words out of the synchronous initialised ROM and pushes them into the FIFO write port. It sits in the fast (write) clock domain, directly upstream of the FIFO. It raises done once the last word has been accepted by the FIFO. It sustains one word per clock while the FIFO has space and never drops or duplicates a word under back-pressure.

## Interface
- DATA_WIDTH, 8, word width of ROM and FIFO data
- DEPTH, 16, number of ROM words
- DATA_AMOUNT, 16, words transferred per run; legal range 1..65535
- ADDR_WIDTH, $clog2(DEPTH), ROM address width (derived, not overridden)

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the next rising edge
- start  input  1  level request; sampled only in IDLE
- done  output  1  high in DONE state
- busy  output  1  high in LOAD state
- rom_en  output  1  ROM read enable; data returns exactly 1 cycle later
- rom_addr  output  ADDR_WIDTH  ROM read address
- rom_data  input  DATA_WIDTH  ROM read data, valid the cycle after rom_en
- fifo_full  input  1  FIFO cannot accept a write this cycle
- fifo_wr_en  output  1  write strobe; a word is transferred when high
- fifo_wr_data  output  DATA_WIDTH  word being written

## Operation
- States: IDLE -> LOAD -> DONE -> IDLE.
- IDLE: start=1 at a rising edge moves to LOAD; issue and write counters are zeroed.
- LOAD issues ROM reads at consecutive addresses 0,1,2,…
  - rom_addr = issue_count mod DEPTH, so reads wrap to 0 when DATA_AMOUNT > DEPTH.
  - Issue stops after DATA_AMOUNT reads.
- Output buffer: 2-entry skid FIFO holding returned ROM words. Every returned word is written into it; it never overflows.
- Issue rule: rom_en = (state==LOAD) && (issue_count < DATA_AMOUNT) && (occupancy + inflight − fifo_wr_en < 2).
  - inflight is 1 if rom_en was high the previous cycle.
- Write rule: fifo_wr_en = (occupancy > 0) && !fifo_full.
  - fifo_wr_data is the buffer head, in ROM order.
  - fifo_wr_en is combinational from fifo_full and registered occupancy.
- LOAD -> DONE on the edge where the DATA_AMOUNT-th write occurs.
- DONE: done=1. Moves to IDLE on an edge where start=0, so a new run needs start to drop and then rise again.
- start is ignored while in LOAD or DONE.
- Counters are $clog2(DATA_AMOUNT+1) bits wide and never wrap within a run.
- Reset mid-run:
  - state goes to IDLE; counters and occupancy go to 0.
  - Any ROM word in flight is discarded.
  - No fifo_wr_en is asserted in the cycle after reset is sampled.

## Timing
- Reset values: done=0, busy=0, rom_en=0, rom_addr=0, fifo_wr_en=0, fifo_wr_data=0.
- Startup: start sampled high at edge N, so cycle N+1 is the first LOAD cycle.
  - N+1: rom_en=1, rom_addr=0.
  - N+2: rom_data valid; captured at the end of N+2.
  - N+3: fifo_wr_en=1 with word 0.
- Without stalls: words 0..DATA_AMOUNT−1 are written at cycles N+3..N+DATA_AMOUNT+2, and done rises at N+DATA_AMOUNT+3.
- Stall: fifo_full=1 for k cycles stalls writes exactly k cycles.
  - At most 2 words are buffered, with no loss.
  - Full rate resumes the cycle fifo_full drops.
- No rom_en in IDLE or DONE. No fifo_wr_en outside LOAD.

## Test plan
- Reset, start=1, fifo_full=0, ROM[i]=i+0x10 -> 16 writes 0x10..0x1F in cycles N+3..N+18; done=1 at N+19; rom_en count = 16.
- Hold fifo_full=1 from cycle N+4 through N+9 -> writes 0x10 at N+3, none in N+4..N+9; 0x11..0x1F contiguous from N+10; no word lost or repeated; occupancy never exceeds 2.
- DATA_AMOUNT=20, DEPTH=16 -> addresses 0..15,0..3 in that order; written words ROM[0..15],ROM[0..3]; done after 20th write.
- Assert reset at cycle N+8 -> outputs return to reset values the next cycle; no writes follow; after a new start, streaming restarts from address 0.
- Keep start=1 through DONE -> stays in DONE with done=1 and no new reads; start=0 then 1 -> second run of 16 identical writes.
- Random fifo_full (50%) over 100 runs -> scoreboard matches ROM order exactly; fifo_wr_en never high while fifo_full=1.
